// File: rtl/mult_shift_add_n.sv
// mult_shift_add_n: sequential unsigned NxN->2N shift-and-add multiplier built on a ripple adder_n.
// adder_n is the shared ripple-carry adder; it is repeated here so the file stands alone.
module adder_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);
    logic [N:0] c;
    assign c[0]  = c_in;
    assign c_out = c[N];
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
endmodule

module mult_shift_add_n #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [N-1:0] m, p_hi, p_lo, s;
    logic c, accept, last;
    logic [CW-1:0] cnt;
    logic [2*N-1:0] step;

    adder_n #(.N(N)) u_add (.a(p_hi), .b(m), .c_in(1'b0), .s(s), .c_out(c));

    always_comb begin
        accept   = (state != RUN) && start;
        last     = (state == RUN) && (cnt == CW'(1));
        step     = p_lo[0] ? {c, s, p_lo[N-1:1]} : {1'b0, p_hi, p_lo[N-1:1]};
        state_nx = accept ? RUN : last ? DONE : (state == RUN) ? RUN : IDLE;
        busy     = state == RUN;
        done     = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m       <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                m    <= a;
                p_hi <= '0;
                p_lo <= b;
                cnt  <= CW'(N);
            end else if (state == RUN) begin
                {p_hi, p_lo} <= step;
                cnt          <= cnt - CW'(1);
                if (last) product <= step;
            end
        end
    end
endmodule
